// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: memory arbiter state encoding and default bus widths.
package cpu_pkg;

   localparam int DEFAULT_AW = 32;
   localparam int DEFAULT_DW = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data ports; data wins unless fetch is starving.
// Optional starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arb_prio #(
   parameter int STARVE_MAX = 4
) (
`ifdef MEM_ARB_STARVE_GUARD_EN
   input  logic clk,
`endif
   input  logic rst_n,
   input  logic idle,
   input  logic if_req,
   input  logic dm_req,
   output logic if_gnt,
   output logic dm_gnt
);

   logic force_if;
   logic grant_ok;

   // Grants are only offered in IDLE and never while reset is held.
   assign grant_ok = idle & rst_n;
   assign dm_gnt   = grant_ok & dm_req & ~force_if;
   assign if_gnt   = grant_ok & if_req & (~dm_req | force_if);

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starve_cnt;

   // Count data wins that left a fetch waiting; any fetch acceptance clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (if_gnt) begin
         starve_cnt <= '0;
      end else if (dm_gnt && if_req && (starve_cnt != CW'(STARVE_MAX))) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign force_if = (starve_cnt == CW'(STARVE_MAX));
`else
   assign force_if = 1'b0;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port with a 3-state FSM.
// Define MEM_ARB_STARVE_GUARD_EN to bound fetch starvation to STARVE_MAX data wins.
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int AW         = DEFAULT_AW,
   parameter int DW         = DEFAULT_DW,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          busy
);

   arb_state_t state;

   mem_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
`ifdef MEM_ARB_STARVE_GUARD_EN
      .clk    (clk),
`endif
      .rst_n  (rst_n),
      .idle   (state == IDLE),
      .if_req (if_req),
      .dm_req (dm_req),
      .if_gnt (if_gnt),
      .dm_gnt (dm_gnt)
   );

   // Accept in IDLE, hold the latched request on the memory port until
   // mem_ready, then pulse the owner's rvalid and always fall back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (dm_gnt) begin
                  state     <= BUSY_DM;
                  busy      <= 1'b1;
                  mem_en    <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
               end else if (if_gnt) begin
                  state     <= BUSY_IF;
                  busy      <= 1'b1;
                  mem_en    <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
               end
            end
            BUSY_IF: begin
               if (mem_ready) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  mem_en    <= 1'b0;
                  mem_we    <= 1'b0;
                  if_rvalid <= 1'b1;
                  if_rdata  <= mem_rdata;
               end
            end
            BUSY_DM: begin
               if (mem_ready) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  mem_en    <= 1'b0;
                  mem_we    <= 1'b0;
                  dm_rvalid <= 1'b1;
                  if (!mem_we) begin
                     dm_rdata <= mem_rdata;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               mem_en <= 1'b0;
               mem_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the parameter AW, default 32, meaning the address width.
REQ-002 The block SHALL have the parameter DW, default 32, meaning the data width.
REQ-003 The block SHALL have the parameter STARVE_MAX, default 4, meaning the number of consecutive lost fetch arbitrations before fetch is forced.
REQ-004 The block SHALL have the port clk, input, width 1, meaning the single clock, rising-edge active.
REQ-005 The block SHALL have the port rst_n, input, width 1, meaning an asynchronous, active-low reset.
REQ-006 The block SHALL have the following fetch-port signals:
- if_req, input, width 1
- if_addr, input, width AW
- if_gnt, output, width 1
- if_rvalid, output, width 1
- if_rdata, output, width DW
REQ-007 The block SHALL have the following data-port signals:
- dm_req, input, width 1
- dm_we, input, width 1
- dm_addr, input, width AW
- dm_wdata, input, width DW
- dm_gnt, output, width 1
- dm_rvalid, output, width 1
- dm_rdata, output, width DW
REQ-008 The block SHALL have the following memory-side signals:
- mem_en, output, width 1
- mem_we, output, width 1
- mem_addr, output, width AW
- mem_wdata, output, width DW
- mem_rdata, input, width DW
- mem_ready, input, width 1, meaning the access completes this cycle
REQ-009 The block SHALL have the port busy, output, width 1, meaning the state is not IDLE.

Function
REQ-010 The FSM SHALL have the states IDLE, BUSY_IF and BUSY_DM.
REQ-011 In IDLE, the grants SHALL be combinational:
- dm_gnt = dm_req and not force_if.
- if_gnt = if_req and (not dm_req or force_if).
- At most one grant SHALL be high in any cycle.
REQ-012 A transaction SHALL be accepted on a rising edge where req and gnt are both high.
- On acceptance, the block SHALL latch addr, we and wdata, and enter BUSY_IF or BUSY_DM.
- In a BUSY state, both gnts SHALL be 0.
REQ-013 In a BUSY state, mem_en SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL drive the latched values.
- For a fetch, mem_we SHALL be 0.
- In IDLE, mem_en SHALL be 0.
REQ-014 On an edge with a BUSY state and mem_ready=1, the block SHALL:
- return to IDLE;
- pulse the owner's rvalid for exactly the next cycle;
- update the owner's rdata from mem_rdata on reads only.
REQ-015 A data write SHALL complete with dm_rvalid=1, and dm_rdata SHALL hold its previous value.
REQ-016 Minimum latency from acceptance edge to rvalid high SHALL be 1 cycle, with mem_ready high in the first BUSY cycle.
- Back-to-back throughput SHALL be 1 transaction per 2 cycles, because IDLE is always revisited.
REQ-017 If mem_ready stays low, the block SHALL stay BUSY indefinitely, and the requests SHALL be ignored.
REQ-018 A requester holding req low SHALL never receive gnt or rvalid.
REQ-019 The block SHALL never issue a spurious rvalid or a double grant for one held request.

Reset
REQ-020 While rst_n=0, the block SHALL hold:
- state = IDLE;
- all gnt, rvalid, mem_en, mem_we and busy = 0;
- rdata, mem_addr and mem_wdata = 0;
- starvation counter = 0.
REQ-021 Reset asserted mid-transaction SHALL abort it immediately.
- No rvalid SHALL follow for the aborted transaction.
- The first cycle after release SHALL be IDLE.

Configuration
REQ-022 With MEM_ARB_STARVE_GUARD_EN defined, the block SHALL keep a counter starve_cnt of width clog2(STARVE_MAX+1).
- starve_cnt SHALL increment, saturating, on each accepted data transaction while if_req=1.
- starve_cnt SHALL clear on each accepted fetch.
- force_if = (starve_cnt == STARVE_MAX).
REQ-023 Without MEM_ARB_STARVE_GUARD_EN, force_if SHALL be constant 0, giving strict data priority, and the counter SHALL be absent.

Structure
REQ-024 The state encoding SHALL be defined as a typedef enum in the shared package cpu_pkg.
- IDLE=2'd0, BUSY_IF=2'd1, BUSY_DM=2'd2.
REQ-025 The default AW/DW constants SHALL be defined in the shared package cpu_pkg.
REQ-026 The arbitration decision (grants plus starvation counter) SHALL be a sub-module, mem_arb_prio.
- The FSM and datapath latch SHALL remain in mem_arbiter.

Verification
REQ-027 Fetch-only read: if_req=1, if_addr=0x80, mem_ready high in the first BUSY cycle, mem_rdata=0x1234 -> if_gnt at the edge, if_rvalid=1 one cycle later, if_rdata=0x1234, dm signals quiet.
REQ-028 Simultaneous requests, guard off: if_req=dm_req=1 (dm_addr=0x100) -> dm granted first, if granted in the next IDLE; if_rvalid follows dm_rvalid by 2 cycles.
REQ-029 Data write: dm_we=1, dm_addr=0x104, dm_wdata=0xCAFE, mem_ready after 3 cycles -> mem_we=1, mem_wdata=0xCAFE for 3 BUSY cycles, dm_rvalid pulse, dm_rdata unchanged.
REQ-030 Starvation, guard on, STARVE_MAX=4: continuous dm_req and if_req -> 4 dm grants, then 1 if grant, pattern repeating.
REQ-031 Reset mid-access: rst_n=0 during BUSY_DM, mem_ready=1 that same cycle -> no dm_rvalid, busy=0, IDLE after release.
REQ-032 Stall: mem_ready held low for 10 cycles with both reqs high -> busy=1, gnts=0 throughout, then exactly one completion.
